// File: rtl/ldo_ctrl_if.sv
// SPI slave pin bundle for ldo_ctrl: chip select, clock and data in/out.
// The master drives cs_n/sclk/mosi; the slave (ldo_ctrl) drives miso.
interface ldo_ctrl_if;
    logic spi_cs_n;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_cs_n,
        output spi_sclk,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_cs_n,
        input  spi_sclk,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/ldo_ctrl.sv
// LDO handover controller: SPI-programmed CTRL/INIT/STATIC registers, thermometer-coded trims
// and a trigger-driven SETTLE/RAMP sequence that hands load from the DLDOs to the ALDO.
module ldo_ctrl (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_trig_n,
    ldo_ctrl_if.slave          spi,
    output logic               status,
    output logic [63:0]        dldo0_en_n,
    output logic [63:0]        dldo1_en_n,
    output logic [14:0]        aldo_en,
    output logic [15:0]        vref_trim,
    output logic [7:0]         ks0_trim,
    output logic [7:0]         ks1_trim,
    output logic [15:0]        r2r_dac_in,
    output logic [2:0]         spare_out
);

    typedef enum logic [1:0] {StIdle, StSettle, StRamp, StDone} state_e;

    function automatic logic [63:0] therm64(input logic [6:0] n);
        logic [63:0] t;
        for (int i = 0; i < 64; i++) t[i] = (7'(i) < n);
        return t;
    endfunction

    function automatic logic [15:0] therm16(input logic [4:0] n);
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = (5'(i) < n);
        return t;
    endfunction

    function automatic logic [14:0] therm15(input logic [3:0] n);
        logic [14:0] t;
        for (int i = 0; i < 15; i++) t[i] = (4'(i) < n);
        return t;
    endfunction

    function automatic logic [7:0] therm8(input logic [3:0] n);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = (4'(i) < n);
        return t;
    endfunction

    // ---------------- SPI slave ----------------
    logic [1:0]  cs_s;
    logic [2:0]  sclk_s;
    logic [1:0]  mosi_s;
    logic [5:0]  bit_cnt_q;
    logic [39:0] rx_q;
    logic [39:0] rx_d;
    logic [31:0] tx_q;
    logic        wr_pend_q;
    logic [31:0] ctrl_q;
    logic [31:0] init_q;
    logic [31:0] static_q;
    logic [31:0] rd_data;
    logic        sclk_rise;
    logic        sclk_fall;

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign rx_d      = {rx_q[38:0], mosi_s[1]};

    // Address is complete in rx_d when the 8th rise is being taken.
    always_comb begin
        rd_data = '0;
        case (rx_d[6:0])
            7'h00:   rd_data = ctrl_q;
            7'h04:   rd_data = init_q;
            7'h08:   rd_data = static_q;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cs_s      <= '0;
            sclk_s    <= '0;
            mosi_s    <= '0;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            wr_pend_q <= 1'b0;
            ctrl_q    <= '0;
            init_q    <= '0;
            static_q  <= '0;
        end else begin
            cs_s      <= {cs_s[0], spi.spi_cs_n};
            sclk_s    <= {sclk_s[1:0], spi.spi_sclk};
            mosi_s    <= {mosi_s[0], spi.spi_mosi};
            wr_pend_q <= 1'b0;
            if (wr_pend_q) begin
                case (rx_q[38:32])
                    7'h00:   ctrl_q   <= rx_q[31:0];
                    7'h04:   init_q   <= rx_q[31:0];
                    7'h08:   static_q <= rx_q[31:0];
                    default: ;
                endcase
            end
            if (cs_s[1]) begin
                bit_cnt_q <= '0;
                tx_q      <= '0;
            end else if (sclk_rise && bit_cnt_q != 6'd40) begin
                rx_q      <= rx_d;
                bit_cnt_q <= bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd7 && rx_d[7]) tx_q <= rd_data;
                if (bit_cnt_q == 6'd39 && !rx_d[39]) wr_pend_q <= 1'b1;
            end else if (sclk_fall && bit_cnt_q >= 6'd9) begin
                // The fall right after the load rise is skipped so bit31 is seen by rise 9.
                tx_q <= {tx_q[30:0], 1'b0};
            end
        end
    end

    assign spi.spi_miso = ~spi.spi_cs_n & tx_q[31];

    // ---------------- Static outputs ----------------
    assign vref_trim  = therm16(static_q[4:0]);
    assign ks0_trim   = therm8(static_q[8:5]);
    assign ks1_trim   = therm8(static_q[12:9]);
    assign spare_out  = static_q[15:13];
    assign r2r_dac_in = static_q[31:16];

    // ---------------- Handover FSM ----------------
    state_e      state_q;
    logic [1:0]  trig_s;
    logic        trig;
    logic [6:0]  cnt0_q;
    logic [6:0]  cnt1_q;
    logic [3:0]  aldo_tgt_q;
    logic [2:0]  step_q;
    logic [3:0]  settle_q;
    logic [7:0]  period_q;
    logic        ramp1_q;
    logic [7:0]  tmr_q;
    logic [6:0]  dec0;
    logic [6:0]  dec1;
    logic [6:0]  nxt1;
    logic        ramp_zero;
    logic        dec_zero;

    assign trig = ~trig_s[1];

    always_comb begin
        dec0      = (cnt0_q >= {4'd0, step_q}) ? cnt0_q - {4'd0, step_q} : 7'd0;
        dec1      = (cnt1_q >= {4'd0, step_q}) ? cnt1_q - {4'd0, step_q} : 7'd0;
        nxt1      = ramp1_q ? dec1 : cnt1_q;
        ramp_zero = (cnt0_q == 7'd0) && (!ramp1_q || cnt1_q == 7'd0);
        dec_zero  = (dec0 == 7'd0) && (!ramp1_q || dec1 == 7'd0);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= StIdle;
            trig_s     <= '0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            aldo_tgt_q <= '0;
            step_q     <= '0;
            settle_q   <= '0;
            period_q   <= '0;
            ramp1_q    <= 1'b0;
            tmr_q      <= '0;
            status     <= 1'b1;
            dldo0_en_n <= '1;
            dldo1_en_n <= '1;
            aldo_en    <= '0;
        end else begin
            trig_s <= {trig_s[0], start_trig_n};
            unique case (state_q)
                StIdle: begin
                    status     <= 1'b1;
                    dldo0_en_n <= ~therm64(init_q[6:0]);
                    dldo1_en_n <= ~therm64(init_q[22:16]);
                    aldo_en    <= '0;
                    if (trig && ctrl_q[0]) begin
                        state_q    <= StSettle;
                        cnt0_q     <= init_q[6:0];
                        cnt1_q     <= init_q[22:16];
                        aldo_tgt_q <= init_q[11:8];
                        step_q     <= {1'b0, ctrl_q[3:2]} + 3'd1;
                        settle_q   <= ctrl_q[7:4];
                        period_q   <= (ctrl_q[15:8] == 8'd0) ? 8'd1 : ctrl_q[15:8];
                        ramp1_q    <= ctrl_q[1];
                        tmr_q      <= '0;
                        status     <= 1'b0;
                        aldo_en    <= therm15(init_q[11:8]);
                    end
                end
                StSettle: begin
                    if (!trig) begin
                        state_q    <= StIdle;
                        status     <= 1'b1;
                        dldo0_en_n <= ~therm64(init_q[6:0]);
                        dldo1_en_n <= ~therm64(init_q[22:16]);
                        aldo_en    <= '0;
                    end else if (tmr_q + 8'd1 >= {4'd0, settle_q}) begin
                        state_q <= StRamp;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + 8'd1;
                    end
                end
                StRamp: begin
                    if (!trig) begin
                        state_q    <= StIdle;
                        status     <= 1'b1;
                        dldo0_en_n <= ~therm64(init_q[6:0]);
                        dldo1_en_n <= ~therm64(init_q[22:16]);
                        aldo_en    <= '0;
                    end else if (ramp_zero) begin
                        state_q <= StDone;
                        status  <= 1'b1;
                    end else if (tmr_q + 8'd1 >= period_q) begin
                        tmr_q      <= '0;
                        cnt0_q     <= dec0;
                        cnt1_q     <= nxt1;
                        dldo0_en_n <= ~therm64(dec0);
                        dldo1_en_n <= ~therm64(nxt1);
                        if (dec_zero) begin
                            state_q <= StDone;
                            status  <= 1'b1;
                        end
                    end else begin
                        tmr_q <= tmr_q + 8'd1;
                    end
                end
                StDone: begin
                    status <= 1'b1;
                    if (!trig) begin
                        state_q    <= StIdle;
                        dldo0_en_n <= ~therm64(init_q[6:0]);
                        dldo1_en_n <= ~therm64(init_q[22:16]);
                        aldo_en    <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ctrl_q[31:16], init_q[31:23], init_q[15:12], init_q[7], aldo_tgt_q};

endmodule

// File: tb/tb_ldo_ctrl.sv
// Directed bench for ldo_ctrl: SPI register access, static trims and handover sequencing.
module tb_ldo_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start_trig_n;
    logic        status;
    logic [63:0] dldo0_en_n;
    logic [63:0] dldo1_en_n;
    logic [14:0] aldo_en;
    logic [15:0] vref_trim;
    logic [7:0]  ks0_trim;
    logic [7:0]  ks1_trim;
    logic [15:0] r2r_dac_in;
    logic [2:0]  spare_out;

    int n_tests = 0;
    int n_fail  = 0;
    localparam int Half = 6;

    ldo_ctrl_if bus ();

    ldo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_trig_n (start_trig_n),
        .spi          (bus),
        .status       (status),
        .dldo0_en_n   (dldo0_en_n),
        .dldo1_en_n   (dldo1_en_n),
        .aldo_en      (aldo_en),
        .vref_trim    (vref_trim),
        .ks0_trim     (ks0_trim),
        .ks1_trim     (ks1_trim),
        .r2r_dac_in   (r2r_dac_in),
        .spare_out    (spare_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic spi_frame(input logic rw, input logic [6:0] addr, input logic [31:0] wdata,
                             input int nbits, output logic [31:0] rdata);
        logic [39:0] frame;
        frame = {rw, addr, wdata};
        rdata = '0;
        @(negedge clk);
        bus.spi_cs_n = 1'b0;
        bus.spi_sclk = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = frame[39-i];
            repeat (Half) @(negedge clk);
            if (i >= 8) rdata = {rdata[30:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            repeat (Half) @(negedge clk);
            bus.spi_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        bus.spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_write(input logic [6:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        spi_frame(1'b0, addr, data, 40, dummy);
    endtask

    task automatic wait_status(input logic want, input int budget, input string tag);
        int k = 0;
        while (status !== want && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {63'd0, status}, {63'd0, want});
    endtask

    initial begin
        logic [31:0] rd;
        int k;
        rst_n        = 1'b1;
        start_trig_n = 1'b1;
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_status", {63'd0, status}, 64'd1);
        check("rst_dldo0", dldo0_en_n, '1);
        check("rst_dldo1", dldo1_en_n, '1);
        check("rst_aldo", {49'd0, aldo_en}, 64'd0);
        check("rst_vref", {48'd0, vref_trim}, 64'd0);
        check("rst_ks", {48'd0, ks0_trim, ks1_trim}, 64'd0);
        check("rst_r2r_spare", {45'd0, r2r_dac_in, spare_out}, 64'd0);
        check("rst_miso", {63'd0, bus.spi_miso}, 64'd0);

        // STATIC register and derived trims
        spi_write(7'h08, 32'h0000_0425);
        spi_frame(1'b1, 7'h08, 32'h0, 40, rd);
        check("static_rd", {32'd0, rd}, 64'h425);
        check("vref", {48'd0, vref_trim}, 64'h001F);
        check("ks0", {56'd0, ks0_trim}, 64'h01);
        check("ks1", {56'd0, ks1_trim}, 64'h03);
        check("r2r", {48'd0, r2r_dac_in}, 64'd0);
        check("spare", {61'd0, spare_out}, 64'd0);

        // INIT/CTRL programming, IDLE outputs
        spi_write(7'h04, 32'h0000_8A1E);
        spi_write(7'h00, 32'h0000_0193);
        spi_frame(1'b1, 7'h04, 32'h0, 40, rd);
        check("init_rd", {32'd0, rd}, 64'h8A1E);
        spi_frame(1'b1, 7'h00, 32'h0, 40, rd);
        check("ctrl_rd", {32'd0, rd}, 64'h193);
        repeat (4) @(negedge clk);
        check("idle_dldo0", dldo0_en_n, 64'hFFFF_FFFF_C000_0000);
        check("idle_dldo1", dldo1_en_n, '1);
        check("idle_aldo", {49'd0, aldo_en}, 64'd0);
        check("idle_status", {63'd0, status}, 64'd1);

        // Full handover
        start_trig_n = 1'b0;
        wait_status(1'b0, 5, "busy_5clk");
        k = 0;
        while (aldo_en !== 15'h03FF && k < 25) begin
            @(negedge clk);
            k++;
        end
        check("aldo_25clk", {49'd0, aldo_en}, 64'h03FF);
        wait_status(1'b1, 125, "done_125clk");
        check("done_dldo0", dldo0_en_n, '1);
        check("done_dldo1", dldo1_en_n, '1);
        repeat (5) @(negedge clk);
        check("done_aldo_hold", {49'd0, aldo_en}, 64'h03FF);

        // Release, retrigger, abort mid-sequence
        start_trig_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rel_status", {63'd0, status}, 64'd1);
        check("rel_dldo0", dldo0_en_n, 64'hFFFF_FFFF_C000_0000);
        start_trig_n = 1'b0;
        repeat (10) @(negedge clk);
        check("retrig_busy", {63'd0, status}, 64'd0);
        start_trig_n = 1'b1;
        wait_status(1'b1, 5, "abort_5clk");
        check("abort_dldo0_b0", {63'd0, dldo0_en_n[0]}, 64'd0);
        check("abort_aldo", {49'd0, aldo_en}, 64'd0);

        // Unmapped address
        spi_frame(1'b1, 7'h10, 32'h0, 40, rd);
        check("unmapped_rd", {32'd0, rd}, 64'd0);
        spi_write(7'h10, 32'hDEAD_BEEF);
        spi_frame(1'b1, 7'h10, 32'h0, 40, rd);
        check("unmapped_wr_rd", {32'd0, rd}, 64'd0);

        // Handover disabled
        spi_write(7'h00, 32'h0000_0192);
        start_trig_n = 1'b0;
        repeat (10) @(negedge clk);
        check("dis_status", {63'd0, status}, 64'd1);
        check("dis_aldo", {49'd0, aldo_en}, 64'd0);
        start_trig_n = 1'b1;
        repeat (4) @(negedge clk);

        // Aborted write frame
        spi_frame(1'b0, 7'h08, 32'hFFFF_FFFF, 20, rd);
        spi_frame(1'b1, 7'h08, 32'h0, 40, rd);
        check("abort_wr_rd", {32'd0, rd}, 64'h425);
        check("abort_wr_vref", {48'd0, vref_trim}, 64'h001F);

        // Reset in the middle of a handover
        spi_write(7'h00, 32'h0000_0193);
        start_trig_n = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_busy", {63'd0, status}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_status", {63'd0, status}, 64'd1);
        check("midrst_dldo0", dldo0_en_n, '1);
        check("midrst_aldo", {49'd0, aldo_en}, 64'd0);
        check("midrst_vref", {48'd0, vref_trim}, 64'd0);
        start_trig_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_frame(1'b1, 7'h00, 32'h0, 40, rd);
        check("midrst_ctrl_rd", {32'd0, rd}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ldo_ctrl.md
LDO_CTRL -- requirements
Module: ldo_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state SHALL update on rising clk only.
REQ-002 clk  input  1  core clock, 100 MHz nominal.
REQ-003 rst_n  input  1  synchronous reset, asserted HIGH (name fixed by codebase; polarity fixed high).
REQ-004 start_trig_n  input  1  asynchronous, active-low handover trigger (level).
REQ-005 status  output  1  1 = ready (IDLE/DONE); 0 = busy (SETTLE/RAMP).
REQ-006 spi_cs_n, spi_sclk, spi_mosi  input  1 each  asynchronous SPI slave inputs, mode 0, MSB first.
REQ-007 spi_miso  output  1  SPI read data; 0 whenever cs_n is high.
REQ-008 dldo0_en_n, dldo1_en_n  output  64 each  active-low thermometer enables.
REQ-009 aldo_en  output  15  active-high thermometer enable.
REQ-010 vref_trim  output  16 / ks0_trim  output  8 / ks1_trim  output  8  thermometer trims.
REQ-011 r2r_dac_in  output  16  binary DAC code; spare_out  output  3  direct spare bits.

Function
REQ-012 Thermometer rule: code N drives bits [N-1:0] active, rest inactive; N above width saturates to all active.
REQ-013 SPI: cs_n, sclk, mosi each pass a 2-flop synchronizer; sclk edges are detected in clk domain.
REQ-014 Frame: bit0 R/W (1 = read), 7-bit address, 32 data bits; mosi sampled on sclk rise.
REQ-015 Write commits to the addressed register on the clk after the 40th rise is detected; cs_n rising before the 40th bit aborts with no update.
REQ-016 Read: after the 8th rise, load the addressed register into a shift register and drive bit31 on miso; shift one bit per detected sclk fall.
REQ-017 Map: 0x00 CTRL, 0x04 INIT, 0x08 STATIC; all 32 bits stored and read back verbatim; other addresses read 0, writes ignored.
REQ-018 STATIC: [4:0] vref code (16-bit therm), [8:5] ks0 code, [12:9] ks1 code, [15:13] spare_out, [31:16] r2r_dac_in; outputs update continuously from the register.
REQ-019 INIT: [6:0] dldo0 init count, [11:8] aldo target count, [22:16] dldo1 init count; other bits reserved.
REQ-020 CTRL: [0] handover enable, [1] dldo1 ramp enable, [3:2] step size minus 1, [7:4] settle cycles, [15:8] step period in cycles (0 treated as 1).
REQ-021 start_trig_n passes a 2-flop synchronizer; trig = synchronized low level.
REQ-022 FSM states IDLE, SETTLE, RAMP, DONE.
REQ-023 IDLE: dldo0 = therm(dldo0 init), dldo1 = therm(dldo1 init), aldo_en = 0, status = 1; trig with CTRL[0]=1 loads counters and goes to SETTLE.
REQ-024 SETTLE: aldo_en = therm(aldo target) from the first SETTLE cycle; status = 0; after CTRL[7:4] cycles go to RAMP.
REQ-025 RAMP: every step-period cycles, dldo0 count decrements by step size, floored at 0; dldo1 does the same if CTRL[1]=1; when every ramping count is 0, go to DONE.
REQ-026 DONE: hold aldo target and final DLDO counts, status = 1; stay while trig held; trig release goes to IDLE.
REQ-027 Trig release in SETTLE or RAMP aborts to IDLE on the next clk: status = 1 and IDLE outputs restored.
REQ-028 CTRL/INIT writes during a handover do not disturb the captured ramp counters; they take effect at the next IDLE entry.

Reset
REQ-029 Reset: all registers = 0; FSM = IDLE; synchronizers and SPI shifter cleared; miso = 0.
REQ-030 Reset outputs: dldo0/1_en_n all ones; aldo_en, vref_trim, ks0/ks1_trim, r2r_dac_in, spare_out = 0; status = 1.
REQ-031 Reset mid-SPI-frame or mid-handover discards the frame or sequence.

Verification
REQ-032 Write 0x08 = 0x00000425, read 0x08 -> 0x00000425; vref_trim = 0x001F, ks0_trim = 0x01, ks1_trim = 0x03, r2r_dac_in = 0, spare_out = 0.
REQ-033 Write INIT = 0x00008A1E, CTRL = 0x00000193, trig high -> dldo0_en_n[29:0] = 0, [63:30] = 1; dldo1_en_n all ones; aldo_en = 0; status = 1.
REQ-034 Trig low -> status = 0 within 5 clk; aldo_en = 0x03FF within 25 clk; status = 1 and dldo0_en_n = all ones within 125 clk.
REQ-035 Trig released after DONE, then low again -> status = 0 after 10 clk; release -> within 5 clk status = 1, dldo0_en_n[0] = 0, aldo_en = 0.
REQ-036 Read of unmapped address 0x10 -> 0; CTRL[0]=0 with trig low -> stays IDLE, status = 1.
REQ-037 cs_n raised after 20 bits of a write frame -> target register unchanged.
